// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand sequencer: state encoding and default sizes.
package mul_pkg;

   localparam int unsigned MUL_WIDTH          = 16;
   localparam int unsigned MUL_TIMEOUT_CYCLES = 70000;
   localparam int unsigned MUL_CNT_W          = 17;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_LOAD_B = 3'd3,
      ST_WAIT   = 3'd4,
      ST_RESP   = 3'd5
   } seq_state_t;

endpackage

// File: rtl/mul_done_edge.sv
// Registers the multiplier's level done signal and reports its rising edge only.
module mul_done_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_done,
   output logic o_rise
);

   logic r_doneQ;

   // A done that is already high yields no edge until it has dropped and risen again.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_doneQ <= 1'b0;
      end else begin
         r_doneQ <= i_done;
      end
   end

   assign o_rise = i_done & ~r_doneQ;

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds operand pairs into the repeated-addition multiplier over its serial load protocol
// and returns the product (or a timeout abort) through a valid/ready result port.
module mul_operand_sequencer
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH          = MUL_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = MUL_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = MUL_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_data,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_timeout,
   output logic [CNT_W-1:0] out_cycles,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LP_WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_t       r_state;
   seq_state_t       w_nextState;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_outResult;
   logic             r_outTimeout;
   logic [CNT_W-1:0] r_outCycles;
   logic             w_doneRise;
   logic             w_complete;
   logic             w_abort;
   logic             w_inReady;
   logic             w_mulStart;
   logic [WIDTH-1:0] w_mulData;
   logic             w_outValid;
   logic             w_busy;

   mul_done_edge u_doneEdge (
      .clk    (clk),
      .rst    (rst),
      .i_done (mul_done),
      .o_rise (w_doneRise)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Handshake and bus outputs are decoded from the current state only.
   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      w_mulStart  = 1'b0;
      w_mulData   = '0;
      w_outValid  = 1'b0;
      w_busy      = 1'b1;
      w_complete  = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_inReady = 1'b1;
            w_busy    = 1'b0;
            if (in_valid) begin
               w_nextState = ST_START;
            end
         end
         ST_START: begin
            w_mulStart  = 1'b1;
            w_nextState = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            w_mulData   = r_a;
            w_nextState = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            w_mulData   = r_b;
            w_nextState = ST_WAIT;
         end
         ST_WAIT: begin
            w_mulData = r_b;
            if (w_doneRise) begin
               w_complete  = 1'b1;
               w_nextState = ST_RESP;
            end else if (r_count == LP_WAIT_LAST) begin
               w_abort     = 1'b1;
               w_nextState = ST_RESP;
            end
         end
         ST_RESP: begin
            w_outValid = 1'b1;
            if (out_ready) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Operand capture, wait counter, and the result registers held stable throughout RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a          <= '0;
         r_b          <= '0;
         r_count      <= '0;
         r_outResult  <= '0;
         r_outTimeout <= 1'b0;
         r_outCycles  <= '0;
      end else begin
         if (r_state == ST_IDLE && in_valid) begin
            r_a <= in_a;
            r_b <= in_b;
         end
         if (r_state == ST_LOAD_B) begin
            r_count <= '0;
         end else if (r_state == ST_WAIT) begin
            r_count <= r_count + 1'b1;
         end
         if (w_complete) begin
            r_outResult  <= mul_result;
            r_outTimeout <= 1'b0;
            r_outCycles  <= r_count;
         end else if (w_abort) begin
            r_outResult  <= '0;
            r_outTimeout <= 1'b1;
            r_outCycles  <= LP_WAIT_LAST;
         end
      end
   end

   assign in_ready    = w_inReady;
   assign mul_start   = w_mulStart;
   assign mul_data    = w_mulData;
   assign out_valid   = w_outValid;
   assign busy        = w_busy;
   assign out_result  = r_outResult;
   assign out_timeout = r_outTimeout;
   assign out_cycles  = r_outCycles;

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Upstream feeder for the repeated-addition multiplier (datapath plus controller).
- Accepts operand pairs over a valid/ready handshake and drives the multiplier's serial load protocol: start pulse, then A, then B on the shared data bus.
- Waits for the multiplier to finish, captures its result, and presents it downstream with a valid/ready handshake.
- Flags a timeout if the multiplier never completes.

Parameters:
- WIDTH, 16, operand/result/data-bus width.
- TIMEOUT_CYCLES, 70000, maximum cycles in WAIT before aborting. Must exceed 2^WIDTH + 8.
- CNT_W, 17, width of the wait-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (repeat count).
- mul_start  out  1  start pulse to multiplier controller.
- mul_data  out  WIDTH  shared data_in bus to multiplier.
- mul_done  in  1  done from multiplier controller (level; may stay high).
- mul_result  in  WIDTH  result from multiplier datapath.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_result  out  WIDTH  captured product (low WIDTH bits).
- out_timeout  out  1  result is a timeout abort, not a product.
- out_cycles  out  CNT_W  number of WAIT cycles the operation took.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (rst=1 at a clock edge), from the next edge:
- state=IDLE.
- in_ready=1, mul_start=0, mul_data=0.
- out_valid=0, out_result=0, out_timeout=0, out_cycles=0, busy=0.
- Operand registers and done_q cleared to 0.
- rst during any state aborts the operation. No output is produced for an aborted operation.

FSM states: IDLE, START, LOAD_A, LOAD_B, WAIT, RESP. All outputs are registered or decoded from state only, with no combinational in-to-out paths.
- IDLE: in_ready=1. On in_valid & in_ready, latch in_a and in_b into A_r and B_r, then go to START.
- START: mul_start=1, mul_data=0, held for exactly 1 cycle. Go to LOAD_A.
- LOAD_A: mul_start=0, mul_data=A_r for 1 cycle. Go to LOAD_B.
- LOAD_B: mul_data=B_r for 1 cycle. Clear the wait counter. Go to WAIT.
- WAIT:
  - mul_data holds B_r. The wait counter increments every cycle.
  - done_q registers mul_done every cycle.
  - Completion is the rising edge of mul_done (mul_done=1 & done_q=0). If mul_done is already high on entry to WAIT, it must first fall; a stale done is never accepted.
  - On completion: out_result <= mul_result, out_timeout <= 0, out_cycles <= counter, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without completion: out_result <= 0, out_timeout <= 1, out_cycles <= TIMEOUT_CYCLES-1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - out_valid=1. out_result, out_timeout and out_cycles stay stable while out_valid & !out_ready.
  - On out_ready, go to IDLE next cycle; out_valid drops on that cycle.
- in_ready=0 in every state except IDLE. There is no overlap between operations: one pair is in flight at a time.
- Latency from input accept to out_valid = 3 load cycles + WAIT cycles + 1.
- Arithmetic: the product is taken as mul_result unchanged, modulo 2^WIDTH; overflow is not detected.
- B=0: the sequencer does not special-case it and waits for the done edge as normal.

Decomposition:
- Shared package mul_pkg holds:
  - state encoding enum (IDLE..RESP, 3 bits);
  - WIDTH default;
  - TIMEOUT_CYCLES default.
- One natural sub-module is mul_done_edge: the done_q register plus rising-edge detect, cleared by rst. Everything else stays in mul_operand_sequencer.

Test Plan:
1. Bench setup: drive the sequencer into the real Mul_datapath/controller pair.
   - Stimulus: in_a=30, in_b=5 accepted.
   - Response: mul_start is high exactly 1 cycle; mul_data shows 0, 30, 5 on successive cycles; out_valid rises with out_result=150, out_timeout=0.
2. Zero and large operands: A=7,B=0 gives out_result=0. A=255,B=255 gives 65025. A=300,B=300 gives 24464 (wraps mod 2^16).
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
   - out_result stays stable.
   - in_ready stays 0, and a second in_valid is not accepted.
   - Releasing out_ready returns to IDLE and the next pair is accepted.
4. Stale/stuck done: use a behavioural multiplier model.
   - mul_done held high throughout: no false completion; out_timeout=1 and out_cycles=TIMEOUT_CYCLES-1, with TIMEOUT_CYCLES=50 for the test.
   - done falling then rising in WAIT: normal completion.
5. Reset mid-operation: assert rst for 1 cycle during WAIT.
   - Next cycle: all outputs at reset values, busy=0, in_ready=1, and no out_valid for the aborted pair.
   - A subsequent 30x5 yields 150.
6. Back-to-back pairs with out_ready tied 1: pairs (3,4) and (10,10).
   - Outputs 12 then 100, in order.
   - out_cycles is monotonic in B across the two results.
